// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      COMMIT = 2'd2,
      INVAL  = 2'd3
   } state_t;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   function automatic int woff_bits(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int idx_bits(input int num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int tag_bits(input int addr_w, input int line_words, input int num_lines);
      return addr_w - 2 - $clog2(line_words) - $clog2(num_lines);
   endfunction

endpackage

// File: rtl/icache_array.sv
// Data/tag/valid storage: combinational read, word write, tag commit, clear-all.
// Data and tag arrays are deliberately unreset; only the valid bits are.
module icache_array
   import icache_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 16,
   parameter int WOFF       = 2,
   parameter int IDX_W      = 4,
   parameter int TAG_W      = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [WOFF-1:0]  rd_off,
   output logic [31:0]      rd_data,
   output logic [TAG_W-1:0] rd_tag,
   output logic             rd_valid,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WOFF-1:0]  wr_off,
   input  logic [31:0]      wr_data,
   input  logic             commit_en,
   input  logic [TAG_W-1:0] commit_tag,
   input  logic             clear_all
);

   logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;

   always_ff @(posedge clk) begin
      if (wr_en)     data_q[wr_idx][wr_off] <= wr_data;
      if (commit_en) tag_q[wr_idx] <= commit_tag;
   end

   // Clear-all wins so an invalidate can never be undone by a same-cycle commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         valid_q <= '0;
      else if (clear_all) valid_q <= '0;
      else if (commit_en) valid_q[wr_idx] <= 1'b1;
   end

   assign rd_data  = data_q[rd_idx][rd_off];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only I-cache controller: hit path, miss refill burst,
// and invalidate-all, stalling fetch until the looked-up line is present.
module icache_ctrl
   import icache_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 16,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] PCF,
   input  logic              icache_inv,
   output logic [31:0]       InstructionF,
   output logic              Mem_Stall,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata,
   output state_t            dbg_state
);

   localparam int WOFF   = woff_bits(LINE_WORDS);
   localparam int IDX_W  = idx_bits(NUM_LINES);
   localparam int TAG_W  = tag_bits(ADDR_W, LINE_WORDS, NUM_LINES);
   localparam int IDX_LO = WOFF + 2;
   localparam int TAG_LO = IDX_LO + IDX_W;

   state_t            state;
   logic [ADDR_W-1:0] miss_addr;
   logic [WOFF-1:0]   beat;
   logic              pending_inv;

   logic [WOFF-1:0]   pc_off;
   logic [IDX_W-1:0]  pc_idx;
   logic [TAG_W-1:0]  pc_tag;
   logic [IDX_W-1:0]  miss_idx;
   logic [TAG_W-1:0]  miss_tag;
   logic [31:0]       rd_data;
   logic [TAG_W-1:0]  rd_tag;
   logic              rd_valid;
   logic              hit;
   logic              unused_pc_lsb;

   assign pc_off        = PCF[IDX_LO-1:2];
   assign pc_idx        = PCF[TAG_LO-1:IDX_LO];
   assign pc_tag        = PCF[ADDR_W-1:TAG_LO];
   assign miss_idx      = miss_addr[TAG_LO-1:IDX_LO];
   assign miss_tag      = miss_addr[ADDR_W-1:TAG_LO];
   assign unused_pc_lsb = ^PCF[1:0];

   icache_array #(
      .LINE_WORDS (LINE_WORDS),
      .NUM_LINES  (NUM_LINES),
      .WOFF       (WOFF),
      .IDX_W      (IDX_W),
      .TAG_W      (TAG_W)
   ) u_array (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx     (pc_idx),
      .rd_off     (pc_off),
      .rd_data    (rd_data),
      .rd_tag     (rd_tag),
      .rd_valid   (rd_valid),
      .wr_en      ((state == REFILL) && mem_ready),
      .wr_idx     (miss_idx),
      .wr_off     (beat),
      .wr_data    (mem_rdata),
      .commit_en  (state == COMMIT),
      .commit_tag (miss_tag),
      .clear_all  (state == INVAL)
   );

   // Only IDLE can hit, so a line being refilled or invalidated never leaks out.
   assign hit          = rd_valid && (rd_tag == pc_tag) && (state == IDLE);
   assign Mem_Stall    = !hit;
   assign InstructionF = hit ? rd_data : NOP_INSN;
   assign dbg_state    = state;

   // Refill handshake: a beat transfers in every cycle where mem_req and
   // mem_ready are both high; mem_req and mem_addr hold steady until it does.
   assign mem_addr = miss_addr + {{(ADDR_W-WOFF-2){1'b0}}, beat, 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         miss_addr   <= '0;
         beat        <= '0;
         pending_inv <= 1'b0;
         mem_req     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (icache_inv) begin
                  state <= INVAL;
               end else if (!hit) begin
                  state     <= REFILL;
                  miss_addr <= {pc_tag, pc_idx, {(WOFF+2){1'b0}}};
                  beat      <= '0;
                  mem_req   <= 1'b1;
               end
            end
            REFILL: begin
               if (icache_inv) pending_inv <= 1'b1;
               if (mem_ready) begin
                  beat <= beat + 1'b1;
                  if (beat == WOFF'(LINE_WORDS-1)) begin
                     state   <= COMMIT;
                     mem_req <= 1'b0;
                  end
               end
            end
            COMMIT: begin
               // A pulse landing on the commit cycle itself is honoured too.
               if (pending_inv || icache_inv) begin
                  state       <= INVAL;
                  pending_inv <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            INVAL: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed plus randomized bench for icache_ctrl against a line-level cache model.
module tb_icache_ctrl;
   import icache_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] PCF;
   logic        icache_inv;
   logic [31:0] InstructionF;
   logic        Mem_Stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   state_t      dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   bit          mvalid [16];
   logic [31:0] mtag   [16];

   icache_ctrl #(.LINE_WORDS(4), .NUM_LINES(16), .ADDR_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .PCF          (PCF),
      .icache_inv   (icache_inv),
      .InstructionF (InstructionF),
      .Mem_Stall    (Mem_Stall),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .dbg_state    (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Backing memory: every word holds a value derived from its own address.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a >> 2) + 32'h9C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
   endtask

   // One cycle: inputs change just after the rising edge, outputs are sampled 1ns later.
   task automatic drive(input logic [31:0] pcf, input logic rdy, input logic inv);
      @(posedge clk);
      #1;
      PCF        = pcf;
      mem_ready  = rdy;
      icache_inv = inv;
      mem_rdata  = mem_fn(mem_addr);
      #1;
   endtask

   task automatic hit_chk(input logic [31:0] pcf);
      drive(pcf, 1'b0, 1'b0);
      chk("hit_stall", {31'd0, Mem_Stall}, 32'd0);
      chk("hit_insn", InstructionF, mem_fn(pcf));
      chk("hit_req", {31'd0, mem_req}, 32'd0);
   endtask

   // Full miss transaction: miss cycle, burst, commit, then either the hit or an invalidate.
   task automatic refill(input logic [31:0] pcf, input bit rnd, input logic [15:0] pat,
                         input int inv_cyc, input bit pre);
      logic [31:0] base;
      int          beats;
      int          cyc;
      int          idx;
      logic        rdy;
      bit          inv_seen;
      base     = pcf & 32'hFFFF_FFF0;
      idx      = int'((pcf / 16) % 16);
      beats    = 0;
      cyc      = 0;
      inv_seen = 1'b0;
      if (pre) begin
         PCF = pcf; mem_ready = 1'b0; icache_inv = 1'b0;
         #1;
      end else begin
         drive(pcf, 1'b0, 1'b0);
      end
      chk("miss_stall", {31'd0, Mem_Stall}, 32'd1);
      chk("miss_req", {31'd0, mem_req}, 32'd0);
      chk("miss_nop", InstructionF, 32'h0000_0013);
      while (beats < 4 && cyc < 200) begin
         rdy = rnd ? 1'($urandom_range(0, 1)) : ((cyc < 16) ? pat[cyc] : 1'b1);
         drive(pcf, rdy, cyc == inv_cyc);
         if (cyc == inv_cyc) inv_seen = 1'b1;
         chk("refill_req", {31'd0, mem_req}, 32'd1);
         chk("refill_addr", mem_addr, base + 32'(4 * beats));
         chk("refill_stall", {31'd0, Mem_Stall}, 32'd1);
         if (rdy) beats++;
         cyc++;
      end
      if (beats < 4) chk("refill_timeout", 32'(beats), 32'd4);
      drive(pcf, 1'b0, 1'b0);
      chk("commit_req", {31'd0, mem_req}, 32'd0);
      chk("commit_stall", {31'd0, Mem_Stall}, 32'd1);
      mvalid[idx] = 1'b1;
      mtag[idx]   = pcf / 256;
      if (inv_seen) begin
         drive(pcf, 1'b0, 1'b0);
         chk("inval_stall", {31'd0, Mem_Stall}, 32'd1);
         chk("inval_req", {31'd0, mem_req}, 32'd0);
         model_clear();
      end else begin
         drive(pcf, 1'b0, 1'b0);
         chk("fill_stall", {31'd0, Mem_Stall}, 32'd0);
         chk("fill_insn", InstructionF, mem_fn(pcf));
      end
   endtask

   initial begin
      logic [31:0] pcf;
      logic [31:0] last_pcf;
      int          idx;

      rst_n = 1'b0; PCF = 32'h10; icache_inv = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_stall", {31'd0, Mem_Stall}, 32'd1);
      chk("rst_insn", InstructionF, 32'h0000_0013);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));

      // Cold miss on 0x10, released on the same edge-cycle as the miss cycle.
      @(posedge clk); #1; rst_n = 1'b1;
      refill(32'h10, 1'b0, 16'hFFFF, -1, 1'b1);
      hit_chk(32'h14);
      hit_chk(32'h18);
      hit_chk(32'h1C);

      // Conflict miss: same index, new tag, then the old line misses again.
      refill(32'h110, 1'b0, 16'hFFFF, -1, 1'b0);
      hit_chk(32'h11C);
      refill(32'h10, 1'b0, 16'hFFFF, -1, 1'b0);

      // Backpressure pattern 1,0,0,1,1,0,1.
      refill(32'h20, 1'b0, 16'h0059, -1, 1'b0);
      hit_chk(32'h24);
      hit_chk(32'h28);
      hit_chk(32'h2C);

      // Invalidate mid-refill at beat 2, then the same PCF misses again.
      refill(32'h30, 1'b0, 16'hFFFF, 2, 1'b0);
      refill(32'h30, 1'b0, 16'hFFFF, -1, 1'b0);

      // Invalidate pulse in IDLE: hit this cycle, INVAL next, then everything misses.
      drive(32'h34, 1'b0, 1'b1);
      chk("idle_inv_stall0", {31'd0, Mem_Stall}, 32'd0);
      chk("idle_inv_insn", InstructionF, mem_fn(32'h34));
      drive(32'h34, 1'b0, 1'b0);
      chk("idle_inv_stall1", {31'd0, Mem_Stall}, 32'd1);
      model_clear();
      refill(32'h34, 1'b0, 16'hFFFF, -1, 1'b0);
      refill(32'h20, 1'b0, 16'hFFFF, -1, 1'b0);

      // Reset in the middle of a burst.
      drive(32'h40, 1'b0, 1'b0);
      chk("mid_miss", {31'd0, Mem_Stall}, 32'd1);
      drive(32'h40, 1'b1, 1'b0);
      drive(32'h40, 1'b1, 1'b0);
      chk("mid_req", {31'd0, mem_req}, 32'd1);
      chk("mid_addr", mem_addr, 32'h44);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
      chk("mid_rst_addr", mem_addr, 32'd0);
      model_clear();
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      refill(32'h40, 1'b0, 16'hFFFF, -1, 1'b1);
      last_pcf = 32'h40;

      // Randomized traffic against the line-level model.
      for (int t = 0; t < 40; t++) begin
         pcf = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 15)) << 4)
             | (32'($urandom_range(0, 3)) << 2);
         if ($urandom_range(0, 7) == 0) begin
            drive(last_pcf, 1'b0, 1'b1);
            chk("rinv_hit", {31'd0, Mem_Stall}, 32'd0);
            drive(last_pcf, 1'b0, 1'b0);
            chk("rinv_stall", {31'd0, Mem_Stall}, 32'd1);
            model_clear();
         end
         idx = int'((pcf / 16) % 16);
         if (mvalid[idx] && mtag[idx] == pcf / 256) hit_chk(pcf);
         else refill(pcf, 1'b1, 16'h0000, -1, 1'b0);
         last_pcf = pcf;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
